// File: rtl/znc_flag_if.sv
// Bus bundle between the register-file/issue side and the ZNC flag unit.
// With ZNC_OVF_EN defined the bundle also carries the signed-overflow flag v.
interface znc_flag_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [2:0]       mask;
    logic             err_clr;
    logic [2:0]       znc;
    logic             out_valid;
    logic             stack_full;
    logic             stack_empty;
    logic             err;
`ifdef ZNC_OVF_EN
    logic             v;
`endif

`ifdef ZNC_OVF_EN
    modport master (
        output in_valid, op, ra, rb, mask, err_clr,
        input  in_ready, znc, out_valid, stack_full, stack_empty, err, v
    );
    modport slave (
        input  in_valid, op, ra, rb, mask, err_clr,
        output in_ready, znc, out_valid, stack_full, stack_empty, err, v
    );
`else
    modport master (
        output in_valid, op, ra, rb, mask, err_clr,
        input  in_ready, znc, out_valid, stack_full, stack_empty, err
    );
    modport slave (
        input  in_valid, op, ra, rb, mask, err_clr,
        output in_ready, znc, out_valid, stack_full, stack_empty, err
    );
`endif
endinterface

// File: rtl/znc_flag_unit.sv
// Registered Z/N/C condition-code unit with compare/test/set/clear/load and a LIFO flag stack.
// Optional macro ZNC_OVF_EN adds the signed-overflow flag v, saved and restored with the stack.
module znc_flag_unit #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    znc_flag_if.slave    bus
);
`ifdef ZNC_OVF_EN
    localparam int FW = 4;
`else
    localparam int FW = 3;
`endif
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam logic [SPW-1:0] SP_MAX = SPW'(STACK_DEPTH);

    localparam logic [2:0] OP_CMP  = 3'd1;
    localparam logic [2:0] OP_SET  = 3'd2;
    localparam logic [2:0] OP_CLR  = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_POP  = 3'd5;
    localparam logic [2:0] OP_TST  = 3'd6;
    localparam logic [2:0] OP_LOAD = 3'd7;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t              state_reg, state_next;
    logic [FW-1:0]       flags_reg, flags_next;
    logic [SPW-1:0]      sp_reg, sp_next;
    logic                err_reg, err_next, err_set;
    logic                out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]    ra_reg, rb_reg;
    logic                tst_reg;
    logic                capture;
    logic                push_we;
    logic                stack_full, stack_empty;
    logic [FW-1:0]       pop_data;
    logic [STACK_DEPTH*FW-1:0] stack_flat;
    logic [WIDTH:0]      diff;
    logic [WIDTH-1:0]    and_res;

    assign stack_full  = (sp_reg == SP_MAX);
    assign stack_empty = (sp_reg == '0);

    // One register per stack slot; sp_reg addresses the next free slot.
    genvar gi;
    generate
        for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            logic [FW-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push_we && sp_reg == SPW'(gi)) begin
                    entry_reg <= flags_reg;
                end
            end
            assign stack_flat[gi*FW +: FW] = entry_reg;
        end
    endgenerate

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_reg == SPW'(i + 1)) begin
                pop_data = stack_flat[i*FW +: FW];
            end
        end
    end

    // Unsigned borrow appears in the extra top bit of the widened difference.
    assign diff    = {1'b0, ra_reg} - {1'b0, rb_reg};
    assign and_res = ra_reg & rb_reg;

    always_comb begin
        state_next     = state_reg;
        flags_next     = flags_reg;
        sp_next        = sp_reg;
        out_valid_next = 1'b0;
        err_set        = 1'b0;
        capture        = 1'b0;
        push_we        = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    case (bus.op)
                        OP_CMP, OP_TST: begin
                            state_next = EXEC;
                            capture    = 1'b1;
                        end
                        OP_SET: begin
                            flags_next[2:0] = flags_reg[2:0] | bus.mask;
                            out_valid_next  = 1'b1;
                        end
                        OP_CLR: begin
                            flags_next[2:0] = flags_reg[2:0] & ~bus.mask;
                            out_valid_next  = 1'b1;
                        end
                        OP_LOAD: begin
                            flags_next[2:0] = bus.mask;
                            out_valid_next  = 1'b1;
                        end
                        OP_PUSH: begin
                            if (stack_full) begin
                                err_set = 1'b1;
                            end else begin
                                push_we = 1'b1;
                                sp_next = sp_reg + 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (stack_empty) begin
                                err_set = 1'b1;
                            end else begin
                                sp_next        = sp_reg - 1'b1;
                                flags_next     = pop_data;
                                out_valid_next = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                state_next     = IDLE;
                out_valid_next = 1'b1;
                if (tst_reg) begin
                    flags_next[2] = ~|and_res;
                    flags_next[1] = and_res[WIDTH-1];
                end else begin
                    flags_next[2] = (diff[WIDTH-1:0] == '0);
                    flags_next[1] = diff[WIDTH-1];
                    flags_next[0] = ~diff[WIDTH];
`ifdef ZNC_OVF_EN
                    flags_next[3] = (ra_reg[WIDTH-1] != rb_reg[WIDTH-1]) &&
                                    (diff[WIDTH-1] != ra_reg[WIDTH-1]);
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    assign err_next = err_set | (err_reg & ~bus.err_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            flags_reg     <= '0;
            sp_reg        <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            ra_reg        <= '0;
            rb_reg        <= '0;
            tst_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flags_reg     <= flags_next;
            sp_reg        <= sp_next;
            err_reg       <= err_next;
            out_valid_reg <= out_valid_next;
            if (capture) begin
                ra_reg  <= bus.ra;
                rb_reg  <= bus.rb;
                tst_reg <= (bus.op == OP_TST);
            end
        end
    end

    assign bus.in_ready    = (state_reg == IDLE);
    assign bus.znc         = flags_reg[2:0];
    assign bus.out_valid   = out_valid_reg;
    assign bus.stack_full  = stack_full;
    assign bus.stack_empty = stack_empty;
    assign bus.err         = err_reg;
`ifdef ZNC_OVF_EN
    assign bus.v           = flags_reg[3];
`endif
endmodule

// File: tb/tb_znc_flag_unit.sv
// Randomised bench for znc_flag_unit against a queue-based flag/stack reference model.
module tb_znc_flag_unit;
    localparam int W = 16;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    znc_flag_if #(.WIDTH(W)) bus ();
    znc_flag_unit #(.WIDTH(W), .STACK_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [2:0] m_znc;
    logic       m_v;
    logic       m_err;
    logic       m_ov;
    logic [3:0] m_stack[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_znc = 3'b000;
        m_v   = 1'b0;
        m_err = 1'b0;
        m_ov  = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_apply(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] m, input logic ec);
        logic e;
        int   d;
        int   sd;
        logic [W-1:0] t;
        logic [3:0] top;
        e    = 1'b0;
        m_ov = 1'b0;
        case (o)
            3'd1: begin
                d     = int'(a) - int'(b);
                sd    = int'($signed(a)) - int'($signed(b));
                m_znc = {a == b, (d & 32'h8000) != 0, a >= b};
                m_v   = (sd > 32767) || (sd < -32768);
                m_ov  = 1'b1;
            end
            3'd2: begin m_znc = m_znc | m;  m_ov = 1'b1; end
            3'd3: begin m_znc = m_znc & ~m; m_ov = 1'b1; end
            3'd4: begin
                if (m_stack.size() == D) e = 1'b1;
                else m_stack.push_back({m_v, m_znc});
            end
            3'd5: begin
                if (m_stack.size() == 0) e = 1'b1;
                else begin
                    top   = m_stack.pop_back();
                    m_znc = top[2:0];
                    m_v   = top[3];
                    m_ov  = 1'b1;
                end
            end
            3'd6: begin
                t        = a & b;
                m_znc[2] = (t == 0);
                m_znc[1] = t[W-1];
                m_ov     = 1'b1;
            end
            3'd7: begin m_znc = m; m_ov = 1'b1; end
            default: ;
        endcase
        if (e) m_err = 1'b1;
        else if (ec) m_err = 1'b0;
    endtask

    task automatic check_state();
        check("znc", 32'(bus.znc), 32'(m_znc));
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("err", 32'(bus.err), 32'(m_err));
        check("stack_full", 32'(bus.stack_full), 32'(m_stack.size() == D));
        check("stack_empty", 32'(bus.stack_empty), 32'(m_stack.size() == 0));
        check("in_ready", 32'(bus.in_ready), 32'd1);
`ifdef ZNC_OVF_EN
        check("v", 32'(bus.v), 32'(m_v));
`endif
    endtask

    // Drives one transfer, holds it through EXEC for CMP/TST, then checks flags and the pulse end.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] m, input logic ec);
        bus.op       = o;
        bus.ra       = a;
        bus.rb       = b;
        bus.mask     = m;
        bus.err_clr  = ec;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        if (o == 3'd1 || o == 3'd6) begin
            check("exec_in_ready", 32'(bus.in_ready), 32'd0);
            check("exec_out_valid", 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        model_apply(o, a, b, m, ec);
        check_state();
        $display("op=%0d ra=%h rb=%h mask=%b clr=%0b -> znc=%b ov=%0b err=%0b depth=%0d",
                 o, a, b, m, ec, bus.znc, bus.out_valid, bus.err, m_stack.size());
        @(posedge clk); #1;
        check("ov_pulse_end", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 3'd0;
        bus.ra       = '0;
        bus.rb       = '0;
        bus.mask     = 3'b000;
        bus.err_clr  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state();
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(3'd1, 16'h0005, 16'h0005, 3'b000, 1'b0);
        check("cmp_eq", 32'(bus.znc), 32'b101);
        do_op(3'd1, 16'h0003, 16'h0007, 3'b000, 1'b0);
        check("cmp_lt", 32'(bus.znc), 32'b010);
        do_op(3'd1, 16'hFFFF, 16'h0001, 3'b000, 1'b0);
        check("cmp_gt", 32'(bus.znc), 32'b011);
        do_op(3'd7, 16'h0, 16'h0, 3'b000, 1'b0);
        do_op(3'd2, 16'h0, 16'h0, 3'b101, 1'b0);
        check("set", 32'(bus.znc), 32'b101);
        do_op(3'd3, 16'h0, 16'h0, 3'b100, 1'b0);
        check("clr", 32'(bus.znc), 32'b001);
        do_op(3'd6, 16'h8000, 16'hF000, 3'b000, 1'b0);
        check("tst", 32'(bus.znc), 32'b011);

        do_op(3'd7, 16'h0, 16'h0, 3'b001, 1'b0);
        do_op(3'd4, 16'h0, 16'h0, 3'b000, 1'b0);
        do_op(3'd7, 16'h0, 16'h0, 3'b010, 1'b0);
        do_op(3'd4, 16'h0, 16'h0, 3'b000, 1'b0);
        do_op(3'd7, 16'h0, 16'h0, 3'b100, 1'b0);
        do_op(3'd5, 16'h0, 16'h0, 3'b000, 1'b0);
        check("pop1", 32'(bus.znc), 32'b010);
        do_op(3'd5, 16'h0, 16'h0, 3'b000, 1'b0);
        check("pop2", 32'(bus.znc), 32'b001);
        do_op(3'd5, 16'h0, 16'h0, 3'b000, 1'b0);
        check("underflow_err", 32'(bus.err), 32'd1);
        check("underflow_znc", 32'(bus.znc), 32'b001);

        do_op(3'd0, 16'h0, 16'h0, 3'b000, 1'b1);
        check("err_clr", 32'(bus.err), 32'd0);
        for (int i = 0; i < 5; i++) do_op(3'd4, 16'h0, 16'h0, 3'b000, 1'b0);
        check("overflow_err", 32'(bus.err), 32'd1);
        do_op(3'd4, 16'h0, 16'h0, 3'b000, 1'b1);
        check("set_wins", 32'(bus.err), 32'd1);
        do_op(3'd0, 16'h0, 16'h0, 3'b000, 1'b1);
        check("err_clr2", 32'(bus.err), 32'd0);

`ifdef ZNC_OVF_EN
        do_op(3'd1, 16'h7FFF, 16'hFFFF, 3'b000, 1'b0);
        check("ovf_v", 32'(bus.v), 32'd1);
`endif

        // reset while a CMP sits in EXEC
        do_op(3'd7, 16'h0, 16'h0, 3'b011, 1'b0);
        bus.op       = 3'd1;
        bus.ra       = 16'h0005;
        bus.rb       = 16'h0005;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_exec_ready", 32'(bus.in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_znc", 32'(bus.znc), 32'b000);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_state();

        for (int i = 0; i < 300; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            do_op(3'($urandom_range(0, 7)), a, b, 3'($urandom),
                  ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
